// File: rtl/adder_tree_acc_if.sv
// rtl/adder_tree_acc_if.sv - beat/result bundle between PE column outputs and the adder tree accumulator
interface adder_tree_acc_if #(
  parameter int NUM_IN = 3,
  parameter int PSUM_W = 18,
  parameter int OUT_W  = 32
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*PSUM_W-1:0] psum_in;
  logic                     in_first;
  logic                     in_last;
  logic [OUT_W-1:0]         out_sum;
  logic                     out_valid;
  logic                     drop_pulse;
  logic                     busy;
  logic                     sat_flag;

  modport master (
    output in_valid, psum_in, in_first, in_last,
    input  out_sum, out_valid, drop_pulse, busy, sat_flag
  );

  modport slave (
    input  in_valid, psum_in, in_first, in_last,
    output out_sum, out_valid, drop_pulse, busy, sat_flag
  );
endinterface

// File: rtl/adder_tree_acc.sv
// rtl/adder_tree_acc.sv - pipelined signed adder tree with group accumulator
// Build option ADDER_TREE_SAT_EN: saturating accumulator with sticky sat_flag (default wraps).
module adder_tree_acc #(
  parameter int NUM_IN = 3,
  parameter int PSUM_W = 18,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_tree_acc_if.slave   bus
);

  localparam int   L        = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
  localparam int   NP       = 1 << L;
  localparam int   TW       = PSUM_W + L;
  localparam int   DEPTH    = (L > 0) ? L : 1;
  localparam int   LAST     = DEPTH - 1;
  localparam logic HAS_TREE = (L > 0);
`ifdef ADDER_TREE_SAT_EN
  localparam int   SW       = OUT_W + 1;
`else
  localparam int   SW       = OUT_W;
`endif

  logic                     fire;
  logic [NP*PSUM_W-1:0]     psum_pad;
  logic signed [TW-1:0]     leaf [NP];

  logic signed [TW-1:0]     node_q [DEPTH][NP];
  logic signed [TW-1:0]     node_d [DEPTH][NP];
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0]         first_q, first_d;
  logic [DEPTH-1:0]         last_q, last_d;

  logic signed [TW-1:0]     st_data;
  logic                     st_vld, st_first, st_last;

  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  acc_new;
  logic signed [SW-1:0]     base_ext, tree_ext, sum_ext;
  logic [OUT_W-1:0]         out_sum_q, out_sum_d;
  logic                     out_valid_q, out_valid_d;
  logic                     drop_q, drop_d;
  logic                     open_q, open_d;
`ifdef ADDER_TREE_SAT_EN
  logic                     sat_q, sat_d;
  logic                     clamped;
`endif

  assign fire     = &bus.in_valid;
  assign psum_pad = (NP*PSUM_W)'(bus.psum_in);

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      leaf[i] = TW'(signed'(psum_pad[i*PSUM_W +: PSUM_W]));
    end
  end

  // Every node is held at the final tree width; each level's true range still fits exactly.
  always_comb begin
    for (int lv = 0; lv < DEPTH; lv++) begin
      for (int n = 0; n < NP; n++) begin
        node_d[lv][n] = '0;
      end
    end
    for (int n = 0; n < NP / 2; n++) begin
      node_d[0][n] = leaf[2*n] + leaf[2*n+1];
    end
    for (int lv = 1; lv < DEPTH; lv++) begin
      for (int n = 0; n < (NP >> (lv + 1)); n++) begin
        node_d[lv][n] = node_q[lv-1][2*n] + node_q[lv-1][2*n+1];
      end
    end
    vld_d[0]   = fire;
    first_d[0] = bus.in_first;
    last_d[0]  = bus.in_last;
    for (int lv = 1; lv < DEPTH; lv++) begin
      vld_d[lv]   = vld_q[lv-1];
      first_d[lv] = first_q[lv-1];
      last_d[lv]  = last_q[lv-1];
    end
  end

  generate
    if (L == 0) begin : g_direct
      assign st_data  = leaf[0];
      assign st_vld   = fire;
      assign st_first = bus.in_first;
      assign st_last  = bus.in_last;
    end else begin : g_tree
      assign st_data  = node_q[LAST][0];
      assign st_vld   = vld_q[LAST];
      assign st_first = first_q[LAST];
      assign st_last  = last_q[LAST];
    end
  endgenerate

  // A first beat starts from zero, so it never clamps; later beats build on the held acc.
  always_comb begin
    base_ext = st_first ? '0 : SW'(acc_q);
    tree_ext = SW'(st_data);
    sum_ext  = base_ext + tree_ext;
`ifdef ADDER_TREE_SAT_EN
    clamped = (sum_ext[OUT_W] != sum_ext[OUT_W-1]);
    if (!clamped) begin
      acc_new = sum_ext[OUT_W-1:0];
    end else if (sum_ext[OUT_W]) begin
      acc_new = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      acc_new = {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    acc_new = sum_ext;
`endif
  end

  always_comb begin
    acc_d       = acc_q;
    open_d      = open_q;
    out_sum_d   = out_sum_q;
    out_valid_d = 1'b0;
    drop_d      = (|bus.in_valid) && !fire;
`ifdef ADDER_TREE_SAT_EN
    sat_d       = sat_q;
`endif
    if (st_vld) begin
      acc_d = acc_new;
      if (st_last) begin
        open_d      = 1'b0;
        out_sum_d   = acc_new;
        out_valid_d = 1'b1;
      end else if (st_first) begin
        open_d = 1'b1;
      end
`ifdef ADDER_TREE_SAT_EN
      sat_d = st_first ? clamped : (sat_q | clamped);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int lv = 0; lv < DEPTH; lv++) begin
        for (int n = 0; n < NP; n++) begin
          node_q[lv][n] <= '0;
        end
      end
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      open_q      <= 1'b0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef ADDER_TREE_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      node_q      <= node_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      open_q      <= open_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
`ifdef ADDER_TREE_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.out_sum    = out_sum_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.drop_pulse = drop_q;
  assign bus.busy       = (HAS_TREE & (|vld_q)) | open_q;
`ifdef ADDER_TREE_SAT_EN
  assign bus.sat_flag   = sat_q;
`else
  assign bus.sat_flag   = 1'b0;
`endif

endmodule
